lifo_reader: RTL
================

Name: lifo_reader

Overview:
- Pop-side companion for the team's `lifo` (used with OUTPUT_REGISTER=0, so pop data is valid in the same cycle).
- Takes a burst command "read N entries", issues pops to the LIFO and delivers the entries on a valid/ready stream.
- Marks the final beat with a last flag.
- Sits between a stack buffer and a downstream consumer that cannot take data every cycle.

Parameters:
- DATA_WIDTH, 32, width of LIFO entries and stream data.
- DEPTH, 32, depth of the attached LIFO; sets the counter width.
- COUNT_WIDTH, $clog2(DEPTH)+1, width of the burst count; must hold DEPTH.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  reset. One clock; reset is synchronous and active-high.
- cmd_valid_i  in  1  burst command valid.
- cmd_ready_o  out  1  command accepted when high together with cmd_valid_i.
- cmd_count_i  in  COUNT_WIDTH  number of entries to read.
- lifo_empty_i  in  1  LIFO empty flag.
- pop_o  out  1  pop strobe to the LIFO.
- pop_data_i  in  DATA_WIDTH  LIFO top-of-stack data (combinational).
- m_valid_o  out  1  stream beat valid.
- m_ready_i  in  1  stream beat accepted.
- m_data_o  out  DATA_WIDTH  beat data.
- m_last_o  out  1  final beat of the burst.
- busy_o  out  1  state != IDLE.
- done_o  out  1  one-cycle pulse when the burst completes.
- done_count_o  out  COUNT_WIDTH  entries delivered; valid while done_o is high, held until the next done.

Behaviour:
- Reset values: cmd_ready_o=1, pop_o=0, m_valid_o=0, m_last_o=0, busy_o=0, done_o=0, done_count_o=0, m_data_o=0. Reset also sets state to IDLE, remaining=0 and buffer occupancy=0.
- States and transitions:
  - IDLE: cmd_ready_o=1. A command handshake loads remaining=cmd_count_i and delivered=0, then goes to DRAIN.
  - DRAIN: when remaining reaches 0 (including a count of 0), goes to FLUSH on the next edge.
  - FLUSH: waits for occupancy to reach 0. In the cycle it sees occupancy==0, done_o=1 and done_count_o=delivered; next state is IDLE.
- Pop rule:
  - pop_o = DRAIN & remaining!=0 & !lifo_empty_i & (occ<2 | (m_valid_o & m_ready_i)).
  - pop_o is purely combinational from state and inputs.
  - On pop: pop_data_i is written into the 2-entry output FIFO with last=(remaining==1), remaining is decremented and delivered is incremented.
- Output buffer:
  - 2-entry FIFO; entries leave in pop order, i.e. reverse push order.
  - m_valid_o = occ!=0. m_data_o and m_last_o come from the head entry and are stable while m_valid_o & !m_ready_i.
  - A write and a read in the same cycle keep occupancy unchanged.
- Throughput: one beat per cycle when m_ready_i is held high. Pop-to-m_valid_o latency is 1 cycle.
- LIFO empty while remaining>0: pops stall and the burst stays in DRAIN indefinitely, unless the optional feature below is enabled.
- Count 0: accepted; no pop and no beat. done_o pulses 2 cycles after the handshake with done_count_o=0.
- Reset mid-burst: state returns to IDLE and buffered entries are discarded. Entries already popped are lost; this is the defined behaviour.
- No back-to-back overlap: the next command is accepted only from IDLE, i.e. at the earliest 1 cycle after done_o.

Optional Feature:
- LIFO_READER_EARLY_STOP_EN.
  - Defined: in DRAIN with remaining>0 and lifo_empty_i=1, the burst ends.
    - remaining is forced to 0 and the state moves to FLUSH.
    - If the buffer is non-empty, the tail entry's last bit is set in that cycle.
    - If the buffer is empty, no last beat is issued.
    - done_count_o reports the short count.
  - Undefined: stall behaviour as in Behaviour; early-stop logic is absent.

Decomposition:
- Package lifo_pkg holds:
  - lifo_reader_state_t enum {IDLE, DRAIN, FLUSH};
  - DATA_WIDTH and DEPTH default constants, shared with `lifo`.
- One sub-module: lifo_skid_buf, a 2-entry FIFO of {last, data} with valid/ready output, write enable, occupancy output and a set-last-on-tail input.

Test Plan:
- Push 10,11,12 into `lifo` (DEPTH 32, OUTPUT_REGISTER 0); command count 3; m_ready_i=1 -> beats 12,11,10 on consecutive cycles; m_last_o only on 10; done_o with done_count_o=3; lifo_empty_i=1.
- Push 0..7; command count 8; m_ready_i low for 5 cycles after the first pop -> pop_o stops after 2 pops; m_data_o holds 7; resuming yields 7..0 with no loss or duplicate.
- Command count 0 -> no pop_o, no m_valid_o; done_o 2 cycles after handshake; done_count_o=0.
- Fill LIFO with 32 entries (-i); command count 32 -> 32 beats in reverse order; last on beat 32; LIFO ends empty.
- Push 2 entries; command count 5:
  - without the macro: 2 beats, then busy_o stays high with no done_o;
  - with LIFO_READER_EARLY_STOP_EN: 2 beats, last set on the second, done_count_o=2.
- Push 6 entries; command count 6; assert reset_i after 3 pops -> next cycle all outputs at reset values; new command count 3 returns the remaining 3 entries.

Source files
------------

// File: rtl/lifo_pkg.sv
// Shared definitions for the lifo stack buffer and its pop-side reader.
package lifo_pkg;

  // Defaults shared with the lifo itself so both sides agree on geometry.
  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_DEPTH      = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    FLUSH = 2'd2
  } lifo_reader_state_t;

endpackage

// File: rtl/lifo_skid_buf.sv
// Two-entry FIFO of {last, data} between the lifo pop port and the output
// stream. Entries leave in write order; set_last_i marks the newest entry
// (the tail) as the final beat of a burst.
module lifo_skid_buf #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  wr_en_i,
  input  logic                  wr_last_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  set_last_i,
  output logic                  rd_valid_o,
  input  logic                  rd_ready_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  rd_last_o,
  output logic [1:0]            occ_o
);

  logic [DATA_WIDTH-1:0] r_data [2];
  logic                  r_last [2];
  logic                  r_wr_ptr;
  logic                  r_rd_ptr;
  logic [1:0]            r_occ;

  logic w_rd;
  logic w_tail;
  logic w_set_last;

  assign w_rd       = (r_occ != 2'd0) && rd_ready_i;
  assign w_tail     = ~r_wr_ptr;
  assign w_set_last = set_last_i && (r_occ != 2'd0);

  assign rd_valid_o = (r_occ != 2'd0);
  assign occ_o      = r_occ;
  // Data is gated so the stream shows zero when nothing is buffered.
  assign rd_data_o  = rd_valid_o ? r_data[r_rd_ptr] : '0;
  // A last mark raised this cycle on a single entry must reach the beat
  // that may leave in the same cycle.
  assign rd_last_o  = rd_valid_o &&
                      (r_last[r_rd_ptr] || (w_set_last && (r_rd_ptr == w_tail)));

  // Pointers, occupancy and last flags.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (reset_i) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_occ    <= 2'd0;
      r_last[0] <= 1'b0;
      r_last[1] <= 1'b0;
    end else begin
      if (w_set_last) r_last[w_tail] <= 1'b1;
      if (wr_en_i) begin
        r_last[r_wr_ptr] <= wr_last_i;
        r_wr_ptr         <= ~r_wr_ptr;
      end
      if (w_rd) r_rd_ptr <= ~r_rd_ptr;
      case ({wr_en_i, w_rd})
        2'b10:   r_occ <= r_occ + 2'd1;
        2'b01:   r_occ <= r_occ - 2'd1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  // Data storage.
  always_ff @(posedge clk_i) begin
    // NOTE: storage is deliberately not reset; occupancy qualifies it and
    // the output is gated, so stale contents are never observed.
    if (wr_en_i) r_data[r_wr_ptr] <= wr_data_i;
  end

endmodule

// File: rtl/lifo_reader.sv
// Burst pop reader for a lifo with combinational pop data: accepts a
// "read N entries" command, pops the lifo and streams the entries out on a
// valid/ready interface with a last flag and a completion pulse.
// Optional: define LIFO_READER_EARLY_STOP_EN to end a burst early when the
// lifo runs empty instead of stalling.
module lifo_reader
  import lifo_pkg::*;
#(
  parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int DEPTH       = DEFAULT_DEPTH,
  parameter int COUNT_WIDTH = $clog2(DEPTH) + 1
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   cmd_valid_i,
  output logic                   cmd_ready_o,
  input  logic [COUNT_WIDTH-1:0] cmd_count_i,
  input  logic                   lifo_empty_i,
  output logic                   pop_o,
  input  logic [DATA_WIDTH-1:0]  pop_data_i,
  output logic                   m_valid_o,
  input  logic                   m_ready_i,
  output logic [DATA_WIDTH-1:0]  m_data_o,
  output logic                   m_last_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [COUNT_WIDTH-1:0] done_count_o
);

  lifo_reader_state_t     r_state;
  logic [COUNT_WIDTH-1:0] r_remaining;
  logic [COUNT_WIDTH-1:0] r_delivered;
  logic [COUNT_WIDTH-1:0] r_done_count;

  logic       w_remaining_nz;
  logic       w_pop;
  logic       w_early_stop;
  logic       w_done;
  logic [1:0] w_occ;
  logic       w_buf_valid;

  assign w_remaining_nz = (r_remaining != '0);

  // Pops are suppressed during reset so no entry leaves the lifo unseen.
  assign w_pop = !reset_i && (r_state == DRAIN) && w_remaining_nz && !lifo_empty_i &&
                 ((w_occ < 2'd2) || (w_buf_valid && m_ready_i));

`ifdef LIFO_READER_EARLY_STOP_EN
  assign w_early_stop = (r_state == DRAIN) && w_remaining_nz && lifo_empty_i;
`else
  assign w_early_stop = 1'b0;
`endif

  assign w_done       = (r_state == FLUSH) && (w_occ == 2'd0);
  assign cmd_ready_o  = (r_state == IDLE);
  assign busy_o       = (r_state != IDLE);
  assign pop_o        = w_pop;
  assign m_valid_o    = w_buf_valid;
  assign done_o       = w_done;
  // The count is live during the done pulse and held afterwards.
  assign done_count_o = w_done ? r_delivered : r_done_count;

  lifo_skid_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_buf (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .wr_en_i    (w_pop),
    .wr_last_i  (r_remaining == COUNT_WIDTH'(1)),
    .wr_data_i  (pop_data_i),
    .set_last_i (w_early_stop),
    .rd_valid_o (w_buf_valid),
    .rd_ready_i (m_ready_i),
    .rd_data_o  (m_data_o),
    .rd_last_o  (m_last_o),
    .occ_o      (w_occ)
  );

  // Burst sequencing: accept, drain the lifo, then wait for the buffer to empty.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state      <= IDLE;
      r_remaining  <= '0;
      r_delivered  <= '0;
      r_done_count <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (cmd_valid_i) begin
            r_remaining <= cmd_count_i;
            r_delivered <= '0;
            r_state     <= DRAIN;
          end
        end
        DRAIN: begin
          if (!w_remaining_nz) begin
            r_state <= FLUSH;
          end else if (w_early_stop) begin
            r_remaining <= '0;
            r_state     <= FLUSH;
          end else if (w_pop) begin
            r_remaining <= r_remaining - COUNT_WIDTH'(1);
            r_delivered <= r_delivered + COUNT_WIDTH'(1);
          end
        end
        FLUSH: begin
          if (w_occ == 2'd0) begin
            r_done_count <= r_delivered;
            r_state      <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
